// File: rtl/game_stats_pkg.sv
// Shared types and constants for the game statistics block.
package game_stats_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {StIdle, StAddLines, StAddScore, StCommit} state_e;

    localparam int unsigned MaxLevel = 20;

    // Base points per line count, four BCD digits each.
    localparam logic [15:0] BasePts1 = 16'h0040;
    localparam logic [15:0] BasePts2 = 16'h0100;
    localparam logic [15:0] BasePts3 = 16'h0300;
    localparam logic [15:0] BasePts4 = 16'h1200;

    // Digit idx of base(n); digits above the table width read as zero.
    function automatic bcd_digit_t base_digit(input logic [2:0] n, input int unsigned idx);
        logic [15:0] pts;
        case (n)
            3'd1:    pts = BasePts1;
            3'd2:    pts = BasePts2;
            3'd3:    pts = BasePts3;
            3'd4:    pts = BasePts4;
            default: pts = '0;
        endcase
        return bcd_digit_t'(pts >> (4 * idx));
    endfunction

endpackage

// File: rtl/game_stats_bcd_digit_add.sv
// Single BCD digit adder with carry in and carry out.
module bcd_digit_add
    import game_stats_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       cin_i,
    output bcd_digit_t sum_o,
    output logic       cout_o
);

    logic [4:0] raw;

    always_comb begin
        raw    = 5'(a_i) + 5'(b_i) + 5'(cin_i);
        cout_o = (raw > 5'd9);
        sum_o  = cout_o ? 4'(raw + 5'd6) : raw[3:0];
    end

endmodule

// File: rtl/game_stats.sv
// Score, line and level counters in BCD; score is accumulated digit-serially
// in a shadow register and committed in one step.
module game_stats
    import game_stats_pkg::*;
#(
    parameter int unsigned NUMBER_LEN = 6,
    parameter int unsigned MAX_LEVEL  = MaxLevel
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       new_game_i,
    input  logic [4:0]                 start_level_i,
    input  logic                       game_over_i,
    input  logic                       clr_valid_i,
    input  logic [2:0]                 clr_lines_i,
    output logic                       clr_ready_o,
    output logic [NUMBER_LEN-1:0][3:0] score_o,
    output logic [NUMBER_LEN-1:0][3:0] lines_o,
    output logic [NUMBER_LEN-1:0][3:0] level_o,
    output logic [4:0]                 level_bin_o
);

    localparam int unsigned IdxW = (NUMBER_LEN > 1) ? $clog2(NUMBER_LEN) : 1;

    state_e                     state_q, state_d;
    logic [NUMBER_LEN-1:0][3:0] acc_q, acc_d;
    logic [NUMBER_LEN-1:0][3:0] score_q, score_d;
    logic [NUMBER_LEN-1:0][3:0] lines_q, lines_d;
    logic [4:0]                 level_q, level_d;
    logic [2:0]                 n_q, n_d;
    logic [4:0]                 lvl_lat_q, lvl_lat_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [4:0]                 pass_q, pass_d;
    logic                       carry_q, carry_d;
    logic                       sat_q, sat_d;
    logic                       ready_en_q;
    logic                       ready;

    // Ripple chain for the single-cycle line update.
    logic [NUMBER_LEN:0]        lines_c;
    logic [NUMBER_LEN-1:0][3:0] lines_sum;

    assign lines_c[0] = 1'b0;

    for (genvar i = 0; i < NUMBER_LEN; i++) begin : g_lines
        bcd_digit_add u_lines_add (
            .a_i    (lines_q[i]),
            .b_i    ((i == 0) ? {1'b0, n_q} : 4'd0),
            .cin_i  (lines_c[i]),
            .sum_o  (lines_sum[i]),
            .cout_o (lines_c[i+1])
        );
    end

    bcd_digit_t base_dig;
    bcd_digit_t score_sum;
    logic       score_cout;

    assign base_dig = base_digit(n_q, 32'(idx_q));

    bcd_digit_add u_score_add (
        .a_i    (acc_q[idx_q]),
        .b_i    (base_dig),
        .cin_i  (carry_q),
        .sum_o  (score_sum),
        .cout_o (score_cout)
    );

    // ready_en_q holds ready low until the first clock after reset release.
    assign ready       = (state_q == StIdle) && ready_en_q && !game_over_i;
    assign clr_ready_o = ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        score_d   = score_q;
        lines_d   = lines_q;
        level_d   = level_q;
        n_d       = n_q;
        lvl_lat_d = lvl_lat_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        carry_d   = carry_q;
        sat_d     = sat_q;
        if (new_game_i) begin
            state_d = StIdle;
            acc_d   = '0;
            score_d = '0;
            lines_d = '0;
            level_d = (32'(start_level_i) > MAX_LEVEL) ? 5'(MAX_LEVEL) : start_level_i;
            idx_d   = '0;
            pass_d  = '0;
            carry_d = 1'b0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr_valid_i && ready && clr_lines_i >= 3'd1 && clr_lines_i <= 3'd4) begin
                        n_d       = clr_lines_i;
                        lvl_lat_d = level_q;
                        acc_d     = score_q;
                        idx_d     = '0;
                        pass_d    = '0;
                        carry_d   = 1'b0;
                        sat_d     = 1'b0;
                        state_d   = StAddLines;
                    end
                end
                StAddLines: begin
                    lines_d = lines_c[NUMBER_LEN] ? {NUMBER_LEN{4'h9}} : lines_sum;
                    // A carry out of the units digit means a multiple of ten was crossed.
                    if (lines_c[1] && 32'(level_q) < MAX_LEVEL) begin
                        level_d = level_q + 5'd1;
                    end
                    state_d = StAddScore;
                end
                StAddScore: begin
                    acc_d[idx_q] = score_sum;
                    if (idx_q == IdxW'(NUMBER_LEN - 1)) begin
                        idx_d   = '0;
                        carry_d = 1'b0;
                        if (score_cout) begin
                            sat_d = 1'b1;
                        end
                        if (pass_q == lvl_lat_q) begin
                            state_d = StCommit;
                        end else begin
                            pass_d = pass_q + 5'd1;
                        end
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        carry_d = score_cout;
                    end
                end
                StCommit: begin
                    score_d = sat_q ? {NUMBER_LEN{4'h9}} : acc_q;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            score_q    <= '0;
            lines_q    <= '0;
            level_q    <= '0;
            n_q        <= '0;
            lvl_lat_q  <= '0;
            idx_q      <= '0;
            pass_q     <= '0;
            carry_q    <= 1'b0;
            sat_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            score_q    <= score_d;
            lines_q    <= lines_d;
            level_q    <= level_d;
            n_q        <= n_d;
            lvl_lat_q  <= lvl_lat_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            carry_q    <= carry_d;
            sat_q      <= sat_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        level_o    = '0;
        level_o[0] = 4'(level_q % 5'd10);
        level_o[1] = 4'(level_q / 5'd10);
    end

    assign score_o     = score_q;
    assign lines_o     = lines_q;
    assign level_bin_o = level_q;

endmodule

// File: doc/game_stats.md
GAME_STATS -- requirements
Module: game_stats

Interface
REQ-001 SHALL have parameter NUMBER_LEN, default 6, giving BCD digits per counter.
REQ-002 SHALL have parameter MAX_LEVEL, default 20, giving the level ceiling.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_n_i, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port new_game_i, input, 1 bit, synchronous start-of-game strobe.
REQ-006 SHALL have port start_level_i, input, 5 bits, binary level loaded at new_game_i.
REQ-007 SHALL have port game_over_i, input, 1 bit; while high, no events are accepted.
REQ-008 SHALL have port clr_valid_i, input, 1 bit, line-clear event valid.
REQ-009 SHALL have port clr_lines_i, input, 3 bits, lines cleared in one event (1..4).
REQ-010 SHALL have port clr_ready_o, output, 1 bit, event accepted when valid && ready.
REQ-011 SHALL have ports score_o, lines_o and level_o, outputs, [NUMBER_LEN-1:0][3:0] each, BCD with digit 0 least significant; these feed the status-text renderer.
REQ-012 SHALL have port level_bin_o, output, 5 bits, binary level for the drop-speed logic.

Function
REQ-013 Points for an event SHALL be base(n) x (L+1), where L is level_bin_o at acceptance and base is 1->40, 2->100, 3->300, 4->1200.
REQ-014 An event with clr_lines_i of 0 or more than 4 SHALL be accepted with no state change, and clr_ready_o SHALL stay high.
REQ-015 FSM states SHALL be IDLE, ADD_LINES, ADD_SCORE and COMMIT; clr_ready_o SHALL be 1 only in IDLE with game_over_i low.
REQ-016 On a valid event, IDLE SHALL latch n and L, then go to ADD_LINES.
REQ-017 ADD_LINES SHALL take 1 cycle: lines += n (BCD); level += 1 if lines crosses a multiple of 10, capped at MAX_LEVEL.
REQ-018 ADD_SCORE SHALL add base(n) into a shadow accumulator digit-serially, one digit per cycle from digit 0 upward, with a registered carry, for L+1 passes of NUMBER_LEN cycles each.
REQ-019 COMMIT SHALL take 1 cycle, copy the accumulator to score_o, then return to IDLE.
REQ-020 clr_ready_o SHALL be low for exactly 2+NUMBER_LEN*(L+1) cycles after the accept edge.
REQ-021 score_o SHALL change only at the COMMIT edge; intermediate sums SHALL never be visible.
REQ-022 A carry out of the top digit in any pass SHALL set a saturate flag, and COMMIT SHALL then write all-9s.
REQ-023 lines_o SHALL saturate at all-9s; level_o SHALL equal level_bin_o in BCD.
REQ-024 new_game_i SHALL clear score, lines and the accumulator, load level with min(start_level_i, MAX_LEVEL), abort any operation and force IDLE.
REQ-025 new_game_i SHALL have priority over a simultaneous clr_valid_i, and that event SHALL be dropped.
REQ-026 game_over_i rising mid-operation SHALL NOT abort the operation; the operation completes and the commit occurs.

Reset
REQ-027 rst_n_i low SHALL asynchronously force state IDLE, all counters and the accumulator to 0, level_bin_o to 0, and clr_ready_o to 0 while asserted.
REQ-028 The first clr_ready_o=1 SHALL occur on the first clock after reset release, provided game_over_i is low.

Structure
REQ-029 A shared package SHALL hold the BCD digit type, the FSM state enum, the base-points table as BCD constants and MAX_LEVEL.
REQ-030 One sub-module, bcd_digit_add, SHALL implement the 4-bit BCD digit + carry-in -> digit + carry-out function; it is used by ADD_LINES and ADD_SCORE.

Verification
REQ-031 Reset, then one event with n=1 at level 0: ready low for 8 cycles, then score 000040, lines 000001, level 000000.
REQ-032 New game with start_level_i=2, then one event with n=4: ready low for 20 cycles, then score 003600, lines 000004, level_bin_o 2.
REQ-033 At level 0, events 4,4,2: after the third event lines=000010, level 1, score 001200+001200+000100=002500 (the third event scored at L=0).
REQ-034 Start level 25, then repeated events with n=4: level_bin_o=20, each event adds 025200; after the 40th event score 999999 and no wrap.
REQ-035 Assert new_game_i during ADD_SCORE with clr_valid_i also high: next cycle IDLE, score 0, ready high, event dropped.
REQ-036 Drive clr_lines_i=0 and clr_lines_i=5, and hold game_over_i high with a valid n=2 event: no output change, and ready stays low under game_over_i.
